// File: rtl/medidor_faixa_uc_if.sv
// Handshake bundle between the range-meter control unit and its datapath:
// status flags travel to the control unit, control strobes travel back.
interface medidor_faixa_uc_if;
    logic pronto_medida;
    logic pronto_tx;
    logic is_ultimo_char;
    logic is_ultimo_char_a;
    logic fim_time;
    logic fim_3sec;

    logic zera;
    logic zera_char;
    logic zera_char_a;
    logic zera_time;
    logic mensurar;
    logic partida_tx;
    logic conta_prox_char;
    logic conta_prox_char_a;
    logic conta_time;
    logic registra_acertou;

    modport master (
        input  pronto_medida, pronto_tx, is_ultimo_char, is_ultimo_char_a, fim_time, fim_3sec,
        output zera, zera_char, zera_char_a, zera_time, mensurar, partida_tx,
               conta_prox_char, conta_prox_char_a, conta_time, registra_acertou
    );

    modport slave (
        output pronto_medida, pronto_tx, is_ultimo_char, is_ultimo_char_a, fim_time, fim_3sec,
        input  zera, zera_char, zera_char_a, zera_time, mensurar, partida_tx,
               conta_prox_char, conta_prox_char_a, conta_time, registra_acertou
    );
endinterface

// File: rtl/medidor_faixa_uc.sv
// Moore control unit of the range meter: measurement, "CDU#" frame, interval and "AAA#" hit frame.
// Optional measurement watchdog enabled by defining MEDIDA_TIMEOUT_EN.
module medidor_faixa_uc #(
    parameter int TIMEOUT_M = 2_500_000,
    parameter int TIMEOUT_N = 22
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ligar,
    medidor_faixa_uc_if.master dp,
    output logic               pronto,
    output logic [3:0]         db_estado
);

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARACAO       = 4'h1,
        MEDE             = 4'h2,
        AGUARDA_MEDIDA   = 4'h3,
        TRANSMITE        = 4'h4,
        ESPERA_TX        = 4'h5,
        PROXIMO_CHAR     = 4'h6,
        VERIFICA         = 4'h7,
        ESPERA_INTERVALO = 4'h8,
        REINICIA         = 4'h9,
        REGISTRA         = 4'hA,
        TRANSMITE_A      = 4'hB,
        ESPERA_TX_A      = 4'hC,
        PROXIMO_CHAR_A   = 4'hD,
        FIM              = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera;
        logic zera_char;
        logic zera_char_a;
        logic zera_time;
        logic mensurar;
        logic partida_tx;
        logic conta_prox_char;
        logic conta_prox_char_a;
        logic conta_time;
        logic registra_acertou;
        logic pronto;
    } saidas_t;

    estado_t estado_r;
    estado_t estado_next_s;
    saidas_t saidas_r;
    logic    timeout_s;

    // Strobes are decoded from the state they belong to; registering the decode
    // of the next state keeps them aligned with that state and glitch-free.
    function automatic saidas_t decode_saidas(input estado_t estado);
        saidas_t s;
        s = '{default: 1'b0};
        case (estado)
            PREPARACAO: begin
                s.zera        = 1'b1;
                s.zera_char   = 1'b1;
                s.zera_char_a = 1'b1;
                s.zera_time   = 1'b1;
            end
            MEDE:             s.mensurar          = 1'b1;
            TRANSMITE:        s.partida_tx        = 1'b1;
            PROXIMO_CHAR:     s.conta_prox_char   = 1'b1;
            VERIFICA:         s.zera_time         = 1'b1;
            ESPERA_INTERVALO: s.conta_time        = 1'b1;
            REINICIA: begin
                s.zera_char = 1'b1;
                s.zera_time = 1'b1;
            end
            REGISTRA: begin
                s.registra_acertou = 1'b1;
                s.zera_char_a      = 1'b1;
            end
            TRANSMITE_A:      s.partida_tx        = 1'b1;
            PROXIMO_CHAR_A:   s.conta_prox_char_a = 1'b1;
            FIM:              s.pronto            = 1'b1;
            default:          s = '{default: 1'b0};
        endcase
        return s;
    endfunction

`ifdef MEDIDA_TIMEOUT_EN
    localparam logic [TIMEOUT_N-1:0] LIMITE = TIMEOUT_N'(TIMEOUT_M - 1);
    logic [TIMEOUT_N-1:0] timeout_cnt_r;

    // Watchdog: cleared on each request, counts while waiting for the echo.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_cnt_r <= '0;
        end else if (estado_r == MEDE) begin
            timeout_cnt_r <= '0;
        end else if (estado_r == AGUARDA_MEDIDA) begin
            timeout_cnt_r <= timeout_cnt_r + TIMEOUT_N'(1);
        end else begin
            timeout_cnt_r <= timeout_cnt_r;
        end
    end

    assign timeout_s = (estado_r == AGUARDA_MEDIDA) && (timeout_cnt_r == LIMITE);
`else
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = ^{TIMEOUT_M, TIMEOUT_N};
    assign timeout_s            = 1'b0;
`endif

    // Next-state logic; frames are never cut short, so ligar is only honoured in wait states.
    always_comb begin
        estado_next_s = estado_r;
        case (estado_r)
            INICIAL:          if (ligar) estado_next_s = PREPARACAO; else estado_next_s = INICIAL;
            PREPARACAO:       estado_next_s = MEDE;
            MEDE:             estado_next_s = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                if (dp.pronto_medida) estado_next_s = TRANSMITE;
                else if (timeout_s)   estado_next_s = PREPARACAO;
                else if (!ligar)      estado_next_s = INICIAL;
                else                  estado_next_s = AGUARDA_MEDIDA;
            end
            TRANSMITE:        estado_next_s = ESPERA_TX;
            ESPERA_TX: begin
                if (!dp.pronto_tx)         estado_next_s = ESPERA_TX;
                else if (dp.is_ultimo_char) estado_next_s = VERIFICA;
                else                        estado_next_s = PROXIMO_CHAR;
            end
            PROXIMO_CHAR:     estado_next_s = TRANSMITE;
            VERIFICA:         if (dp.fim_3sec) estado_next_s = REGISTRA; else estado_next_s = ESPERA_INTERVALO;
            ESPERA_INTERVALO: begin
                if (dp.fim_time) estado_next_s = REINICIA;
                else if (!ligar) estado_next_s = INICIAL;
                else             estado_next_s = ESPERA_INTERVALO;
            end
            REINICIA:         estado_next_s = MEDE;
            REGISTRA:         estado_next_s = TRANSMITE_A;
            TRANSMITE_A:      estado_next_s = ESPERA_TX_A;
            ESPERA_TX_A: begin
                if (!dp.pronto_tx)           estado_next_s = ESPERA_TX_A;
                else if (dp.is_ultimo_char_a) estado_next_s = FIM;
                else                          estado_next_s = PROXIMO_CHAR_A;
            end
            PROXIMO_CHAR_A:   estado_next_s = TRANSMITE_A;
            FIM:              if (ligar) estado_next_s = FIM; else estado_next_s = INICIAL;
            default:          estado_next_s = INICIAL;
        endcase
    end

    // State register and registered output strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r <= INICIAL;
            saidas_r <= '{default: 1'b0};
        end else begin
            estado_r <= estado_next_s;
            saidas_r <= decode_saidas(estado_next_s);
        end
    end

    assign dp.zera              = saidas_r.zera;
    assign dp.zera_char         = saidas_r.zera_char;
    assign dp.zera_char_a       = saidas_r.zera_char_a;
    assign dp.zera_time         = saidas_r.zera_time;
    assign dp.mensurar          = saidas_r.mensurar;
    assign dp.partida_tx        = saidas_r.partida_tx;
    assign dp.conta_prox_char   = saidas_r.conta_prox_char;
    assign dp.conta_prox_char_a = saidas_r.conta_prox_char_a;
    assign dp.conta_time        = saidas_r.conta_time;
    assign dp.registra_acertou  = saidas_r.registra_acertou;
    assign pronto               = saidas_r.pronto;
    assign db_estado            = estado_r;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Self-checking bench for medidor_faixa_uc: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural reference.
module tb_medidor_faixa_uc;
    localparam int TM = 100;

    logic       clock;
    logic       reset;
    logic       ligar;
    logic       pronto;
    logic [3:0] db_estado;

    medidor_faixa_uc_if dp();

    medidor_faixa_uc #(.TIMEOUT_M(TM), .TIMEOUT_N(22)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .dp(dp),
        .pronto(pronto), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit l, pm, ptx, uc, uca, ft, f3;
        int code;
    } vec_t;

    vec_t        tbl[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] out_mask [16];
    int          char_cnt, char_a_cnt;
    int          n_tx, n_cpc, n_cpca, n_reg;

    function automatic logic [10:0] outs_now();
        return {dp.zera, dp.zera_char, dp.zera_char_a, dp.zera_time, dp.mensurar, dp.partida_tx,
                dp.conta_prox_char, dp.conta_prox_char_a, dp.conta_time, dp.registra_acertou, pronto};
    endfunction

    // Expected next state code from the state table of the control unit.
    function automatic int ref_next(input int s, input bit l, pm, ptx, uc, uca, ft, f3, tmo);
        case (s)
            0:  return l ? 1 : 0;
            1:  return 2;
            2:  return 3;
            3:  return pm ? 4 : (tmo ? 1 : (l ? 3 : 0));
            4:  return 5;
            5:  return !ptx ? 5 : (uc ? 7 : 6);
            6:  return 4;
            7:  return f3 ? 10 : 8;
            8:  return ft ? 9 : (l ? 8 : 0);
            9:  return 2;
            10: return 11;
            11: return 12;
            12: return !ptx ? 12 : (uca ? 14 : 13);
            13: return 11;
            14: return l ? 14 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic void add(input bit l, pm, ptx, uc, uca, ft, f3, input int code);
        vec_t v;
        v.l = l; v.pm = pm; v.ptx = ptx; v.uc = uc; v.uca = uca; v.ft = ft; v.f3 = f3; v.code = code;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input int exp_code);
        check({name, "/estado"}, int'(db_estado), exp_code);
        check({name, "/saidas"}, int'(outs_now()), int'(out_mask[exp_code]));
    endtask

    // One clock; afterwards the datapath model reacts to the strobes just seen.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        dp.is_ultimo_char   = (char_cnt == 3);
        dp.is_ultimo_char_a = (char_a_cnt == 3);
        if (dp.zera_char) char_cnt = 0; else if (dp.conta_prox_char) char_cnt++;
        if (dp.zera_char_a) char_a_cnt = 0; else if (dp.conta_prox_char_a) char_a_cnt++;
        n_tx   += int'(dp.partida_tx);
        n_cpc  += int'(dp.conta_prox_char);
        n_cpca += int'(dp.conta_prox_char_a);
        n_reg  += int'(dp.registra_acertou);
    endtask

    task automatic clear_counts();
        n_tx = 0; n_cpc = 0; n_cpca = 0; n_reg = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; ligar = 1'b0;
        dp.pronto_medida = 1'b0; dp.pronto_tx = 1'b0; dp.is_ultimo_char = 1'b0;
        dp.is_ultimo_char_a = 1'b0; dp.fim_time = 1'b0; dp.fim_3sec = 1'b0;
        char_cnt = 0; char_a_cnt = 0;
        clear_counts();
        repeat (2) @(negedge clock);
        check_state("reset", 0);
        reset = 1'b1;
    endtask

    // Echo 10 clocks into the wait, transmitter done every 20 clocks; optional ligar drop.
    task automatic run_to(input int target, input int drop_at, output bit reached);
        int in3;
        in3 = 0;
        reached = 1'b0;
        for (int c = 0; c < 3000 && !reached; c++) begin
            dp.pronto_medida = (db_estado == 4'h3) && (in3 == 10);
            in3 = (db_estado == 4'h3) ? in3 + 1 : 0;
            dp.pronto_tx = ((c % 20) == 19);
            if (drop_at > 0 && db_estado == 4'h5 && n_tx == drop_at) ligar = 1'b0;
            tick();
            if (int'(db_estado) == target) reached = 1'b1;
        end
        dp.pronto_medida = 1'b0;
        dp.pronto_tx = 1'b0;
        if (!reached) $display("FAIL run_to: state 0x%0h not reached within budget", target);
    endtask

    initial begin
        bit r;
        bit stayed;
        int exp_s, nxt, wait_cnt, base, base_a;
        bit tmo;

        out_mask[0]  = 11'b00000000000; out_mask[1]  = 11'b11110000000;
        out_mask[2]  = 11'b00001000000; out_mask[3]  = 11'b00000000000;
        out_mask[4]  = 11'b00000100000; out_mask[5]  = 11'b00000000000;
        out_mask[6]  = 11'b00000010000; out_mask[7]  = 11'b00010000000;
        out_mask[8]  = 11'b00000000100; out_mask[9]  = 11'b01010000000;
        out_mask[10] = 11'b00100000010; out_mask[11] = 11'b00000100000;
        out_mask[12] = 11'b00000000000; out_mask[13] = 11'b00000001000;
        out_mask[14] = 11'b00000000001; out_mask[15] = 11'b00000000000;

        //   l pm ptx uc uca ft f3  next
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 4);
        add(1, 0, 1, 0, 0, 0, 0, 5);   // pronto_tx alongside partida_tx is ignored
        add(1, 0, 0, 0, 0, 0, 0, 5);
        add(1, 0, 1, 0, 0, 0, 0, 6);
        add(0, 0, 0, 0, 0, 0, 0, 4);   // ligar=0 ignored mid-frame
        add(0, 0, 0, 0, 0, 0, 0, 5);
        add(0, 0, 1, 1, 0, 0, 0, 7);
        add(0, 0, 0, 0, 0, 0, 0, 8);
        add(1, 0, 0, 0, 0, 0, 0, 8);
        add(0, 0, 0, 0, 0, 1, 0, 9);   // fim_time beats ligar=0
        add(1, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 4);
        add(1, 0, 0, 0, 0, 0, 0, 5);
        add(1, 0, 1, 1, 0, 0, 1, 7);
        add(1, 0, 0, 0, 0, 0, 1, 10);
        add(1, 0, 0, 0, 0, 0, 0, 11);
        add(0, 0, 1, 0, 0, 0, 0, 12);
        add(0, 0, 0, 0, 1, 0, 0, 12);
        add(0, 0, 1, 0, 0, 0, 0, 13);
        add(0, 0, 0, 0, 0, 0, 0, 11);
        add(0, 0, 0, 0, 0, 0, 0, 12);
        add(0, 0, 1, 0, 1, 0, 0, 14);
        add(1, 0, 0, 0, 0, 0, 0, 14);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 4);
        add(1, 0, 0, 0, 0, 0, 0, 5);
        add(1, 0, 1, 1, 0, 0, 0, 7);
        add(1, 0, 0, 0, 0, 0, 0, 8);
        add(0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        do_reset();
        foreach (tbl[i]) begin
            ligar = tbl[i].l; dp.pronto_medida = tbl[i].pm; dp.pronto_tx = tbl[i].ptx;
            dp.is_ultimo_char = tbl[i].uc; dp.is_ultimo_char_a = tbl[i].uca;
            dp.fim_time = tbl[i].ft; dp.fim_3sec = tbl[i].f3;
            tick();
            check_state($sformatf("tbl[%0d]", i), tbl[i].code);
        end

        // Asynchronous reset in the middle of a character.
        do_reset();
        ligar = 1'b1;
        run_to(5, 0, r);
        check("A_reach", int'(r), 1);
        reset = 1'b0;
        #1;
        check_state("A_reset_async", 0);
        @(negedge clock);
        reset = 1'b1;
        ligar = 1'b0;
        tick();
        check_state("A_idle", 0);

        // Full frame, interval, restart, then hit frame.
        do_reset();
        ligar = 1'b1;
        run_to(8, 0, r);
        check("B_reach", int'(r), 1);
        check("B_partida", n_tx, 4);
        check("B_prox_char", n_cpc, 3);
        check_state("B_intervalo", 8);
        dp.fim_time = 1'b1;
        tick();
        dp.fim_time = 1'b0;
        check_state("B_reinicia", 9);
        tick();
        check_state("B_mede", 2);
        clear_counts();
        dp.fim_3sec = 1'b1;
        run_to(14, 0, r);
        check("C_reach", int'(r), 1);
        check("C_partida", n_tx, 8);
        check("C_registra", n_reg, 1);
        check("C_prox_char_a", n_cpca, 3);
        check_state("C_fim", 14);
        tick();
        tick();
        check_state("C_fim_hold", 14);
        ligar = 1'b0;
        tick();
        check_state("C_off", 0);

        // ligar dropped while waiting on the second character.
        do_reset();
        ligar = 1'b1;
        run_to(8, 2, r);
        check("E_reach", int'(r), 1);
        check("E_ligar_dropped", int'(ligar), 0);
        check("E_partida", n_tx, 4);
        check_state("E_intervalo", 8);
        tick();
        check_state("E_off", 0);

        // Echo that never arrives.
        do_reset();
        ligar = 1'b1;
        tick(); tick(); tick();
        check_state("T_aguarda", 3);
`ifdef MEDIDA_TIMEOUT_EN
        for (int k = 1; k < TM; k++) tick();
        check_state("T_antes", 3);
        tick();
        check_state("T_prep", 1);
        tick();
        check_state("T_remede", 2);
`else
        stayed = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (db_estado != 4'h3) stayed = 1'b0;
        end
        check("T_espera", int'(stayed), 1);
`endif

        // Randomized run against the reference model.
        do_reset();
        exp_s = 0; wait_cnt = 0; base = 0; base_a = 0;
        for (int i = 0; i < 3000; i++) begin
            ligar            = ($urandom_range(0, 15) != 0);
            dp.pronto_medida = ($urandom_range(0, 7) == 0);
            dp.pronto_tx     = ($urandom_range(0, 3) == 0);
            dp.fim_time      = ($urandom_range(0, 5) == 0);
            dp.fim_3sec      = ($urandom_range(0, 4) == 0);
            tmo = 1'b0;
`ifdef MEDIDA_TIMEOUT_EN
            tmo = (exp_s == 3) && (wait_cnt == TM - 1);
`endif
            nxt = ref_next(exp_s, ligar, dp.pronto_medida, dp.pronto_tx, dp.is_ultimo_char,
                           dp.is_ultimo_char_a, dp.fim_time, dp.fim_3sec, tmo);
            wait_cnt = (exp_s == 3 && nxt == 3) ? wait_cnt + 1 : 0;
            tick();
            check_state("rand", nxt);
            if (nxt == 2) base = n_tx;
            if (nxt == 7) check("rand_quadro", n_tx - base, 4);
            if (nxt == 10) base_a = n_tx;
            if (nxt == 14 && exp_s != 14) check("rand_quadro_a", n_tx - base_a, 4);
            exp_s = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/medidor_faixa_uc.md
Name: medidor_faixa_uc

Overview:
Moore control unit for the range-meter datapath. Sequences measurement requests, 4-character measurement frames ("CDU#"), inter-measurement spacing and the final "AAA#" hit frame. It consumes the datapath status flags and drives every datapath control strobe. It has no arithmetic of its own beyond an optional watchdog counter.

Parameters:
TIMEOUT_M, 2_500_000, watchdog limit in clocks for an echo that never completes (50 ms at 50 MHz); used only with the optional feature.
TIMEOUT_N, 22, watchdog counter width; must satisfy 2^TIMEOUT_N > TIMEOUT_M.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset; forces state inicial
ligar  in  1  level enable from the user; 1 = run, 0 = stop
pronto_medida  in  1  datapath: one-cycle pulse, new measurement registered
pronto_tx  in  1  datapath: serial transmitter finished the current character
is_ultimo_char  in  1  datapath: measurement character counter at 3 ('#')
is_ultimo_char_a  in  1  datapath: hit character counter at 3 ('#')
fim_time  in  1  datapath: inter-measurement interval elapsed
fim_3sec  in  1  datapath: object held inside range for the hold time (sticky)
zera  out  1  datapath global clear
zera_char, zera_char_a, zera_time  out  1 each  synchronous counter clears
mensurar  out  1  one-cycle measurement request
partida_tx  out  1  one-cycle transmitter start
conta_prox_char, conta_prox_char_a  out  1 each  character counter increments
conta_time  out  1  interval counter enable
registra_acertou  out  1  one-cycle load of the hit flag
pronto  out  1  hit frame fully sent
db_estado  out  4  current state code

Behaviour:
- All outputs are registered-state decodes (Moore): asserted only in the listed states, 0 elsewhere. During reset = 0, state = inicial and all outputs are 0 except db_estado = 0x0.
- States and codes:
  - inicial 0x0: ligar=1 -> preparacao.
  - preparacao 0x1: zera, zera_char, zera_char_a, zera_time = 1 -> mede.
  - mede 0x2: mensurar = 1 -> aguarda_medida.
  - aguarda_medida 0x3: pronto_medida=1 -> transmite; else ligar=0 -> inicial.
  - transmite 0x4: partida_tx = 1 -> espera_tx.
  - espera_tx 0x5: waits for pronto_tx=1, then:
    - is_ultimo_char=1 -> verifica.
    - otherwise -> proximo_char.
  - proximo_char 0x6: conta_prox_char = 1 -> transmite.
  - verifica 0x7: fim_3sec=1 -> registra; else -> espera_intervalo with zera_time.
  - espera_intervalo 0x8: conta_time = 1; fim_time=1 -> reinicia; ligar=0 -> inicial (fim_time has priority).
  - reinicia 0x9: zera_char, zera_time = 1 -> mede.
  - registra 0xA: registra_acertou = 1, zera_char_a = 1 -> transmite_a.
  - transmite_a 0xB: partida_tx = 1 -> espera_tx_a.
  - espera_tx_a 0xC: waits for pronto_tx=1, then:
    - is_ultimo_char_a=1 -> fim.
    - otherwise -> proximo_char_a.
  - proximo_char_a 0xD: conta_prox_char_a = 1 -> transmite_a.
  - fim 0xE: pronto = 1; ligar=0 -> inicial.
  - Unused code 0xF -> inicial.
- Exactly one partida_tx pulse per character. Frame = 4 pulses; the hit frame adds 4 more.
- ligar=0 while in transmite/espera_tx/proximo_char or the _a chain is ignored until the frame completes. Characters are never truncated.
- pronto_tx arriving in the same cycle as partida_tx belongs to the previous character and is not waited on. The transmitter pronto is only sampled in espera_tx/espera_tx_a.
- Latency: preparacao to first mensurar = 1 clock. pronto_medida to partida_tx = 1 clock.

Optional Feature:
MEDIDA_TIMEOUT_EN:
- Defined: a TIMEOUT_N-bit counter is cleared in mede and counts in aguarda_medida. Reaching TIMEOUT_M-1 without pronto_medida -> preparacao (full datapath clear and retry). pronto_medida in the same cycle wins.
- Undefined: no counter is instantiated, and aguarda_medida waits indefinitely.

Test Plan:
- reset=0 mid-transmission (state 0x5) -> db_estado=0x0 immediately and all outputs 0, before the next clock edge.
- ligar=1, pronto_medida after 10 clocks, pronto_tx each 20 clocks, fim_3sec=0 -> exactly 4 partida_tx pulses with 3 conta_prox_char between them, then state 0x8 with conta_time=1.
- Continuing, fim_time pulse -> reinicia (zera_char=1 one cycle) -> mensurar pulse exactly 2 clocks after fim_time.
- fim_3sec=1 at verifica -> registra_acertou one cycle, 4 more partida_tx, pronto=1 held; drop ligar -> 0x0 next clock.
- ligar dropped during espera_tx of character 2 -> remaining characters still sent, state returns 0x0 only after waiting in 0x8.
- With MEDIDA_TIMEOUT_EN, TIMEOUT_M=100, no pronto_medida -> preparacao 100 clocks after entering 0x3, second mensurar pulse follows. Without the macro, the state stays 0x3 for ≥1000 clocks.
